// File: rtl/cla_addsub_pipe.sv
// ---------------------------------------------------------------------------
// cla_addsub_pipe
//   Two-stage pipelined carry-lookahead adder/subtractor for the ALU datapath.
//   The carry chain is cut at the half-word boundary. Stage 1 adds the low
//   half. Stage 2 adds the high half using the registered low carry, forms the
//   flags, and registers the result. The block accepts one operation per cycle
//   and uses a valid/ready handshake on both sides.
//
//   Subtraction is computed as a + ~b + 1: b is inverted and the carry-in is 1.
//
// Optional feature
//   CLA_ADDSUB_SATURATE_EN : when defined, op[1]=1 clamps an overflowing
//                            result to the most positive or most negative
//                            value. When undefined, op[1] is ignored.
//
// Parameters
//   WIDTH      operand/result width; must be a multiple of 8 so that each half
//              is made of whole 4-bit CLA groups
//
// Ports
//   clk        rising-edge clock
//   rst        synchronous active-high reset; discards in-flight operations
//   in_valid   operands/op presented          in_ready  operation accepted
//   a, b       two's complement operands      op        {saturate, subtract}
//   out_valid  result/flags valid             out_ready consumer takes result
//   sum        result (saturated when enabled and requested)
//   cout       raw carry out of the MSB       ovfl      raw signed overflow
//   zero       sum == 0                       neg       sum[WIDTH-1]
// ---------------------------------------------------------------------------

// Carry-lookahead adder for one half-word. It is built from 4-bit groups,
// each with its own internal lookahead, plus a group-level G/P lookahead.
module cla_addsub_pipe_half #(
  parameter int N = 8
) (
  input  logic [N-1:0] i_a,
  input  logic [N-1:0] i_b,
  input  logic         i_cin,
  output logic [N-1:0] o_sum,
  output logic         o_cout
);
  localparam int NG = N / 4;

  logic [N-1:0]  w_g;
  logic [N-1:0]  w_p;
  logic [N-1:0]  w_c;
  logic [NG-1:0] w_gg;
  logic [NG-1:0] w_gp;
  logic [NG-1:0] w_gc;

  assign w_g = i_a & i_b;
  assign w_p = i_a ^ i_b;

  genvar gi;
  generate
    for (gi = 0; gi < NG; gi++) begin : g_grp
      logic [3:0] w_gl;
      logic [3:0] w_pl;
      logic       w_ci;

      assign w_gl = w_g[4*gi +: 4];
      assign w_pl = w_p[4*gi +: 4];
      assign w_ci = w_gc[gi];

      // Group generate/propagate feed the group-level lookahead.
      assign w_gg[gi] = w_gl[3]
                      | (w_pl[3] & w_gl[2])
                      | (w_pl[3] & w_pl[2] & w_gl[1])
                      | (w_pl[3] & w_pl[2] & w_pl[1] & w_gl[0]);
      assign w_gp[gi] = &w_pl;

      // Bit carries inside the group depend only on the group carry-in.
      assign w_c[4*gi+0] = w_ci;
      assign w_c[4*gi+1] = w_gl[0] | (w_pl[0] & w_ci);
      assign w_c[4*gi+2] = w_gl[1] | (w_pl[1] & w_gl[0])
                         | (w_pl[1] & w_pl[0] & w_ci);
      assign w_c[4*gi+3] = w_gl[2] | (w_pl[2] & w_gl[1])
                         | (w_pl[2] & w_pl[1] & w_gl[0])
                         | (w_pl[2] & w_pl[1] & w_pl[0] & w_ci);
    end
  endgenerate

  // Group carries are computed from group G/P only. A local variable carries
  // the value through the loop so the vector has no self-dependency.
  always_comb begin
    logic v_c;
    w_gc = '0;
    v_c  = i_cin;
    for (int k = 0; k < NG; k++) begin
      w_gc[k] = v_c;
      v_c     = w_gg[k] | (w_gp[k] & v_c);
    end
    o_cout = v_c;
  end

  assign o_sum = w_p ^ w_c;
endmodule

module cla_addsub_pipe #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [1:0]       op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovfl,
  output logic             zero,
  output logic             neg
);
  localparam int H = WIDTH / 2;

  // Handshake
  logic w_s2_adv;
  logic w_s1_adv;
  logic w_accept;

  // Stage 1
  logic [WIDTH-1:0] w_b_eff;
  logic [H-1:0]     w_lo_sum;
  logic             w_lo_cout;
  logic             r_s1_v;
  logic [H-1:0]     r_s1_sum_lo;
  logic             r_s1_c;
  logic [H-1:0]     r_s1_a_hi;
  logic [H-1:0]     r_s1_b_hi;

  // Stage 2
  logic [H-1:0]     w_hi_sum;
  logic             w_hi_cout;
  logic [WIDTH-1:0] w_raw;
  logic             w_c_msb;
  logic             w_ovfl;
  logic [WIDTH-1:0] w_sum;
  logic             r_s2_v;
  logic [WIDTH-1:0] r_sum;
  logic             r_cout;
  logic             r_ovfl;
  logic             r_zero;
  logic             r_neg;

  assign w_s2_adv = !r_s2_v | out_ready;
  assign w_s1_adv = !r_s1_v | w_s2_adv;
  assign w_accept = in_valid & w_s1_adv;
  assign in_ready = w_s1_adv;

  // ---------------- Stage 1: low half ----------------
  assign w_b_eff = op[0] ? ~b : b;

  cla_addsub_pipe_half #(.N(H)) u_lo (
    .i_a    (a[H-1:0]),
    .i_b    (w_b_eff[H-1:0]),
    .i_cin  (op[0]),
    .o_sum  (w_lo_sum),
    .o_cout (w_lo_cout)
  );

`ifdef CLA_ADDSUB_SATURATE_EN
  logic r_s1_sat;
`else
  // op[1] only selects saturation, which is not built in this configuration.
  logic w_unused_op1;
  assign w_unused_op1 = op[1];
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      r_s1_v      <= 1'b0;
      r_s1_sum_lo <= '0;
      r_s1_c      <= 1'b0;
      r_s1_a_hi   <= '0;
      r_s1_b_hi   <= '0;
`ifdef CLA_ADDSUB_SATURATE_EN
      r_s1_sat    <= 1'b0;
`endif
    end else if (w_s1_adv) begin
      r_s1_v <= in_valid;
      if (w_accept) begin
        r_s1_sum_lo <= w_lo_sum;
        r_s1_c      <= w_lo_cout;
        r_s1_a_hi   <= a[WIDTH-1:H];
        r_s1_b_hi   <= w_b_eff[WIDTH-1:H];
`ifdef CLA_ADDSUB_SATURATE_EN
        r_s1_sat    <= op[1];
`endif
      end
    end
  end

  // ---------------- Stage 2: high half, flags ----------------
  cla_addsub_pipe_half #(.N(H)) u_hi (
    .i_a    (r_s1_a_hi),
    .i_b    (r_s1_b_hi),
    .i_cin  (r_s1_c),
    .o_sum  (w_hi_sum),
    .o_cout (w_hi_cout)
  );

  assign w_raw   = {w_hi_sum, r_s1_sum_lo};
  // Carry into the MSB is recovered from the MSB sum bit (s = a ^ b ^ cin).
  assign w_c_msb = r_s1_a_hi[H-1] ^ r_s1_b_hi[H-1] ^ w_hi_sum[H-1];
  assign w_ovfl  = w_c_msb ^ w_hi_cout;

`ifdef CLA_ADDSUB_SATURATE_EN
  // A raw MSB of 1 on overflow means two positives wrapped negative, so the
  // result clamps to the most positive value. Otherwise it clamps to the most
  // negative value.
  always_comb begin
    w_sum = w_raw;
    if (r_s1_sat && w_ovfl) begin
      w_sum = w_raw[WIDTH-1] ? {1'b0, {(WIDTH-1){1'b1}}}
                             : {1'b1, {(WIDTH-1){1'b0}}};
    end
  end
`else
  assign w_sum = w_raw;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      r_s2_v <= 1'b0;
      r_sum  <= '0;
      r_cout <= 1'b0;
      r_ovfl <= 1'b0;
      r_zero <= 1'b0;
      r_neg  <= 1'b0;
    end else if (w_s2_adv) begin
      r_s2_v <= r_s1_v;
      // Only real data is loaded. While the stage drains, the last result
      // stays visible.
      if (r_s1_v) begin
        r_sum  <= w_sum;
        r_cout <= w_hi_cout;
        r_ovfl <= w_ovfl;
        r_zero <= (w_sum == '0);
        r_neg  <= w_sum[WIDTH-1];
      end
    end
  end

  assign out_valid = r_s2_v;
  assign sum       = r_sum;
  assign cout      = r_cout;
  assign ovfl      = r_ovfl;
  assign zero      = r_zero;
  assign neg       = r_neg;
endmodule

// File: tb/tb_cla_addsub_pipe.sv
module tb_cla_addsub_pipe;
  localparam int  W = 16;
  localparam time P = 10;

  typedef struct packed {
    logic [W-1:0] sum;
    logic         cout;
    logic         ovfl;
    logic         zero;
    logic         neg;
  } exp_t;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic [1:0]   op = 2'b00;
  logic         out_valid;
  logic         out_ready = 1'b1;
  logic [W-1:0] sum;
  logic         cout;
  logic         ovfl;
  logic         zero;
  logic         neg;

  int   checks = 0;
  int   failures = 0;
  exp_t sb[$];
  time  pop_t[$];

  cla_addsub_pipe #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .op        (op),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .cout      (cout),
    .ovfl      (ovfl),
    .zero      (zero),
    .neg       (neg)
  );

  initial forever #(P/2) clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp_v);
    end
  endtask

  function automatic exp_t mk(input logic [W-1:0] s, input logic c, input logic o,
                              input logic z, input logic n);
    exp_t e;
    e.sum = s; e.cout = c; e.ovfl = o; e.zero = z; e.neg = n;
    return e;
  endfunction

  // Behavioural reference: 17-bit integer add of a and effective b.
  function automatic exp_t model(input logic [W-1:0] ia, input logic [W-1:0] ib,
                                 input logic [1:0] iop);
    logic [W-1:0] be;
    logic [W:0]   full;
    exp_t         e;
    be     = iop[0] ? ~ib : ib;
    full   = {1'b0, ia} + {1'b0, be} + {{W{1'b0}}, iop[0]};
    e.sum  = full[W-1:0];
    e.cout = full[W];
    e.ovfl = (ia[W-1] == be[W-1]) && (full[W-1] != ia[W-1]);
`ifdef CLA_ADDSUB_SATURATE_EN
    if (iop[1] && e.ovfl) e.sum = full[W-1] ? 16'h7FFF : 16'h8000;
`endif
    e.zero = (e.sum == '0);
    e.neg  = e.sum[W-1];
    return e;
  endfunction

  // Output monitor: samples just after the falling edge, so it sees inputs the
  // stimulus drove on that edge. It pops one expectation per handshake.
  always @(negedge clk) begin
    #1;
    if (!rst && out_valid && out_ready) begin
      if (sb.size() == 0) begin
        check("unexpected_output", {31'b0, out_valid}, 32'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        $display("OUT t=%0t sum=%h cout=%b ovfl=%b zero=%b neg=%b (exp sum=%h)",
                 $time, sum, cout, ovfl, zero, neg, e.sum);
        check("out_sum",  {16'b0, sum},  {16'b0, e.sum});
        check("out_cout", {31'b0, cout}, {31'b0, e.cout});
        check("out_ovfl", {31'b0, ovfl}, {31'b0, e.ovfl});
        check("out_zero", {31'b0, zero}, {31'b0, e.zero});
        check("out_neg",  {31'b0, neg},  {31'b0, e.neg});
      end
      pop_t.push_back($time);
    end
  end

  // Present one operation at a falling edge and hold it until it is accepted.
  // The expectation is queued at the accepting edge.
  task automatic issue(input logic [W-1:0] ia, input logic [W-1:0] ib,
                       input logic [1:0] iop, input exp_t e, input bit want_rdy);
    int n;
    a = ia; b = ib; op = iop; in_valid = 1'b1;
    #1;
    if (want_rdy) check("in_ready_on_issue", {31'b0, in_ready}, 32'd1);
    n = 0;
    while (!in_ready && n < 50) begin
      @(negedge clk); #1; n++;
    end
    if (n >= 50) check("accept_timeout", {31'b0, in_ready}, 32'd1);
    @(posedge clk);
    sb.push_back(e);
    $display("IN  t=%0t a=%h b=%h op=%b", $time, ia, ib, iop);
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  // Issue into an empty pipe with out_ready=1, then check the 2-cycle latency.
  task automatic issue_lat(input logic [W-1:0] ia, input logic [W-1:0] ib,
                           input logic [1:0] iop, input exp_t e);
    issue(ia, ib, iop, e, 1'b1);
    #2;
    check("lat_not_yet", {31'b0, out_valid}, 32'd0);
    @(negedge clk); #2;
    check("lat_two_cycles", {31'b0, out_valid}, 32'd1);
  endtask

  initial begin
    int n;
    @(negedge clk); @(negedge clk);
    rst = 1'b0;
    #2;
    check("rst_out_valid", {31'b0, out_valid}, 32'd0);
    check("rst_sum",       {16'b0, sum},       32'd0);
    check("rst_zero",      {31'b0, zero},      32'd0);
    check("rst_flags",     {29'b0, cout, ovfl, neg}, 32'd0);
    check("rst_in_ready",  {31'b0, in_ready},  32'd1);
    @(negedge clk);

    // Directed vectors.
    issue_lat(16'h7FFF, 16'h0001, 2'b00, mk(16'h8000, 0, 1, 0, 1));
    issue_lat(16'h00FF, 16'h0001, 2'b00, mk(16'h0100, 0, 0, 0, 0));
    issue_lat(16'hFFFF, 16'h0001, 2'b00, mk(16'h0000, 1, 0, 1, 0));
    issue_lat(16'h0005, 16'h0005, 2'b01, mk(16'h0000, 1, 0, 1, 0));
    issue_lat(16'h8000, 16'h0001, 2'b01, mk(16'h7FFF, 1, 1, 0, 0));
    issue_lat(16'h8000, 16'h8000, 2'b00, mk(16'h0000, 1, 1, 1, 0));
`ifdef CLA_ADDSUB_SATURATE_EN
    issue_lat(16'h7FFF, 16'h0001, 2'b10, mk(16'h7FFF, 0, 1, 0, 0));
    issue_lat(16'h8000, 16'h0001, 2'b11, mk(16'h8000, 1, 1, 0, 1));
`else
    issue_lat(16'h7FFF, 16'h0001, 2'b10, mk(16'h8000, 0, 1, 0, 1));
    issue_lat(16'h8000, 16'h0001, 2'b11, mk(16'h7FFF, 1, 1, 0, 0));
`endif
    repeat (2) @(negedge clk);

    // Backpressure: two accepts fill the pipe, the third op is held off.
    out_ready = 1'b0;
    issue(16'd1, 16'd1, 2'b00, mk(16'h0002, 0, 0, 0, 0), 1'b1);
    issue(16'd2, 16'd2, 2'b00, mk(16'h0004, 0, 0, 0, 0), 1'b1);
    a = 16'd3; b = 16'd3; op = 2'b00; in_valid = 1'b1;
    #1;
    check("bp_in_ready_low", {31'b0, in_ready}, 32'd0);
    check("bp_out_valid",    {31'b0, out_valid}, 32'd1);
    check("bp_sum",          {16'b0, sum}, 32'h0002);
    repeat (3) begin
      @(negedge clk); #1;
      check("bp_hold_ready", {31'b0, in_ready}, 32'd0);
      check("bp_hold_sum",   {16'b0, sum}, 32'h0002);
      check("bp_hold_valid", {31'b0, out_valid}, 32'd1);
    end
    @(negedge clk);
    pop_t.delete();
    out_ready = 1'b1;
    #1;
    check("bp_in_ready_comb", {31'b0, in_ready}, 32'd1);
    @(posedge clk);
    sb.push_back(mk(16'h0006, 0, 0, 0, 0));
    $display("IN  t=%0t a=0003 b=0003 op=00", $time);
    @(negedge clk);
    in_valid = 1'b0;
    repeat (2) @(negedge clk);
    #2;
    check("bp_pop_count", pop_t.size(), 32'd3);
    if (pop_t.size() == 3) begin
      check("bp_consec_1", 32'(pop_t[1] - pop_t[0]), 32'(P));
      check("bp_consec_2", 32'(pop_t[2] - pop_t[1]), 32'(P));
    end
    @(negedge clk);

    // Sustained stream of 8 ops with out_ready held high.
    pop_t.delete();
    for (int i = 0; i < 8; i++) begin
      logic [W-1:0] va;
      logic [W-1:0] vb;
      logic [1:0]   vo;
      va = $urandom_range(0, 16'hFFFF);
      vb = $urandom_range(0, 16'hFFFF);
      vo = 2'(i % 2);
      issue(va, vb, vo, model(va, vb, vo), 1'b1);
    end
    repeat (3) @(negedge clk);
    #2;
    check("stream_pop_count", pop_t.size(), 32'd8);
    if (pop_t.size() == 8) begin
      for (int i = 1; i < 8; i++) check("stream_no_bubble", 32'(pop_t[i] - pop_t[i-1]), 32'(P));
    end

    // Reset with both stages full.
    out_ready = 1'b0;
    issue(16'h4000, 16'h4000, 2'b00, model(16'h4000, 16'h4000, 2'b00), 1'b1);
    issue(16'h1111, 16'h2222, 2'b00, model(16'h1111, 16'h2222, 2'b00), 1'b1);
    rst = 1'b1;
    sb.delete();
    @(negedge clk);
    rst = 1'b0;
    #2;
    check("mid_rst_out_valid", {31'b0, out_valid}, 32'd0);
    check("mid_rst_sum",       {16'b0, sum}, 32'd0);
    check("mid_rst_flags",     {28'b0, cout, ovfl, zero, neg}, 32'd0);
    check("mid_rst_in_ready",  {31'b0, in_ready}, 32'd1);
    out_ready = 1'b1;
    repeat (3) begin
      @(negedge clk); #2;
      check("mid_rst_no_stale", {31'b0, out_valid}, 32'd0);
    end
    issue_lat(16'h1234, 16'h0001, 2'b00, mk(16'h1235, 0, 0, 0, 0));

    n = 0;
    while (sb.size() != 0 && n < 20) begin
      @(negedge clk); n++;
    end
    #2;
    check("scoreboard_drained", sb.size(), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
